// File: rtl/shifter_seq_if.sv
// +----------------------------------------------------------------------+
// | shifter_seq_if : start/busy/done handshake bundle for shifter_seq    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface shifter_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, op, din, shamt,
    input  busy, done, dout
  );

  modport slave (
    input  start, op, din, shamt,
    output busy, done, dout
  );
endinterface

`default_nettype wire

// File: rtl/shifter_seq.sv
// +----------------------------------------------------------------------+
// | shifter_seq : multi-cycle shift unit, up to STEP bit positions/cycle |
// | Optional rotate ops (ROL/ROR) under macro SHIFTER_SEQ_ROTATE_EN      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 1
) (
  input  logic          clk,
  input  logic          reset,
  shifter_seq_if.slave  bus
);

  localparam int           SW     = SHW + 1;
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
`ifdef SHIFTER_SEQ_ROTATE_EN
  localparam logic [SW-1:0] WIDTH_W = SW'(WIDTH);
`endif

  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
`ifdef SHIFTER_SEQ_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, done_q;

  logic             op_valid;
  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    op_valid = 1'b0;
    case (bus.op)
      OP_SLL, OP_SRL, OP_SRA: op_valid = 1'b1;
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL, OP_ROR:         op_valid = 1'b1;
`endif
      default:                op_valid = 1'b0;
    endcase
  end

  // Bits moved this cycle: the full step, or whatever is left if smaller.
  always_comb begin
    step_amt = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
  end

  always_comb begin
    shifted = dout_q;
    case (op_q)
      OP_SLL:  shifted = dout_q << step_amt;
      OP_SRL:  shifted = dout_q >> step_amt;
      OP_SRA:  shifted = $unsigned($signed(dout_q) >>> step_amt);
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL:  shifted = (dout_q << step_amt) | (dout_q >> (WIDTH_W - step_amt));
      OP_ROR:  shifted = (dout_q >> step_amt) | (dout_q << (WIDTH_W - step_amt));
`endif
      default: shifted = dout_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    case (state_q)
      // A zero remaining count on entry still spends one cycle here (N >= 1).
      S_SHIFT: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          dout_d = shifted;
          rem_d  = rem_q - step_amt[SHW-1:0];
          if (rem_d == '0) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          op_d    = bus.op;
          rem_d   = op_valid ? bus.shamt : '0;
          dout_d  = op_valid ? bus.din : '0;
          state_d = S_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      busy_q  <= (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule

`default_nettype wire
